hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the decode-stage stall logic of the 5-stage MIPS pipeline.
- Replaces per-stage Tnew/Tuse comparisons with a per-GPR countdown scoreboard covering NSRC source operands.
- Adds an internal multiply/divide busy timer and a pending-EPC-write timer.
- Sits beside the ID stage. Its stall output freezes PC/IF/ID and injects a bubble into EX.

Parameters:
NSRC, 3, number of source operand ports checked per decoded instruction
TW, 2, width of tnew/tuse fields and of each GPR countdown counter
MD_W, 4, width of the multiply/divide countdown
MULT_LAT, 5, busy cycles loaded for a multiply start
DIV_LAT, 10, busy cycles loaded for a divide start
EPC_LAT, 2, cycles after MTC0-to-EPC issue before ERET may read EPC

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
freeze  input  1  global pipeline hold (memory wait); nothing advances
flush  input  1  exception/ERET flush of ID/EX/MEM
id_valid  input  1  ID holds a real instruction
id_src_en  input  NSRC  per-source read enable
id_src_addr  input  NSRC*5  source GPR numbers, source i at [5i+4:5i]
id_src_tuse  input  NSRC*TW  cycles until source i is consumed (0 = in ID)
id_dst_we  input  1  instruction writes a GPR
id_dst_addr  input  5  destination GPR
id_tnew  input  TW  cycles after issue until result is forwardable
id_md_start  input  1  instruction starts mult/div
id_md_is_div  input  1  selects DIV_LAT over MULT_LAT
id_md_use  input  1  instruction touches HI/LO or the MD unit
id_cp0_we  input  1  MTC0
id_cp0_addr  input  5  CP0 register number
id_eret  input  1  ERET in ID
stall  output  1  hold ID, bubble into EX
stall_cause  output  3  {eret, md, data}
md_busy  output  1  MD countdown nonzero
pending_mask  output  32  bit r set when cnt[r] != 0 (debug)

Behaviour:
- State:
  - cnt[1..31], each TW bits (r0 has no storage; cnt[0] reads 0).
  - md_cnt, MD_W bits.
  - epc_cnt, 2 bits (saturating; EPC_LAT ≤ 3).
- Reset: all counters 0, so stall=0, stall_cause=0, md_busy=0, pending_mask=0.
- Hazard terms (combinational, current state only, zero input-to-state latency):
  - data_i = id_valid & src_en[i] & addr_i!=0 & cnt[addr_i] > tuse_i (unsigned).
  - data = OR over i of data_i.
  - md = id_valid & id_md_use & md_cnt!=0.
  - eret = id_valid & id_eret & epc_cnt!=0.
  - stall = ~flush & (data|md|eret); stall_cause gated identically.
- issue = id_valid & ~stall & ~freeze & ~flush.
- Per clock, when ~freeze:
  - Every nonzero counter decrements by 1. This happens during stall, because older stages advance.
  - On issue with id_dst_we & dst!=0: cnt[dst] <= id_tnew. This overrides the decrement for that entry, and a younger writer overwrites the older entry.
  - On issue with id_md_start: md_cnt <= (is_div ? DIV_LAT : MULT_LAT), overriding the decrement.
  - On issue with id_cp0_we & addr==14: epc_cnt <= EPC_LAT.
- freeze=1: all counters hold; stall is still driven combinationally.
- flush=1 (when ~freeze):
  - All cnt[] and epc_cnt clear to 0.
  - md_cnt keeps decrementing, since an in-flight mult/div is not cancelled.
  - No issue that cycle. flush has priority over freeze for the counter clear.
- tnew=0 writes leave the counter at 0, so results forwardable immediately never stall.
- md_cnt and epc_cnt never underflow; they stop at 0.

Test Plan:
- Load r8 (tnew=2) issued, then a consumer of r8 with tuse=1 -> stall=1, cause=001 for exactly 1 cycle, then issues.
- ALU r9 (tnew=1), then BEQ r9,r0 (tuse=0) -> 1 stall cycle. Load r9 then BEQ -> 2 stall cycles.
- DIV issued, then MFLO next cycle -> stall=1, cause=010 for 10 cycles, md_busy falls the same cycle stall does. MULT, same check -> 5 cycles.
- MTC0 $14, then ERET -> stall for 2 cycles with cause=100. MTC0 $12, then ERET -> no stall.
- Load r4 then consumer with freeze=1 for 3 cycles -> cnt[4] holds at 2 and stall persists. After freeze drops -> 1 stall cycle.
- flush during pending r5 (cnt=2) -> pending_mask=0 next cycle and consumer issues without stall. Write to r0 with tnew=2 -> no stall, pending_mask[0]=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_scoreboard
//  Purpose  : Decode-stage interlock for the 5-stage MIPS pipeline. Tracks a
//             per-GPR countdown until each in-flight result can be forwarded,
//             plus a mult/div busy timer and a pending EPC write timer, and
//             raises stall when the instruction in ID would consume a value
//             too early.
//  Revision : 1.0  initial parametrised scoreboard
// ============================================================================
module hazard_scoreboard #(
    parameter int NSRC     = 3,
    parameter int TW       = 2,
    parameter int MD_W     = 4,
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int EPC_LAT  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [NSRC-1:0]      id_src_en,
    input  logic [NSRC*5-1:0]    id_src_addr,
    input  logic [NSRC*TW-1:0]   id_src_tuse,
    input  logic                 id_dst_we,
    input  logic [4:0]           id_dst_addr,
    input  logic [TW-1:0]        id_tnew,
    input  logic                 id_md_start,
    input  logic                 id_md_is_div,
    input  logic                 id_md_use,
    input  logic                 id_cp0_we,
    input  logic [4:0]           id_cp0_addr,
    input  logic                 id_eret,
    output logic                 stall,
    output logic [2:0]           stall_cause,
    output logic                 md_busy,
    output logic [31:0]          pending_mask
);

    localparam logic [4:0]      CP0_EPC      = 5'd14;
    localparam logic [MD_W-1:0] MD_MULT_LOAD = MD_W'(MULT_LAT);
    localparam logic [MD_W-1:0] MD_DIV_LOAD  = MD_W'(DIV_LAT);
    localparam logic [1:0]      EPC_LOAD     = 2'(EPC_LAT);
    localparam logic [TW-1:0]   CNT_ONE      = TW'(1);
    localparam logic [MD_W-1:0] MD_ONE       = MD_W'(1);

    // r0 never gets storage: it is hardwired zero in the architecture
    logic [TW-1:0]   cnt_q  [1:31];
    logic [TW-1:0]   cnt_d  [1:31];
    logic [TW-1:0]   cnt_rd [0:31];
    logic [MD_W-1:0] md_cnt_q;
    logic [MD_W-1:0] md_cnt_d;
    logic [1:0]      epc_cnt_q;
    logic [1:0]      epc_cnt_d;

    logic [NSRC-1:0] data_hit;
    logic            haz_data;
    logic            haz_md;
    logic            haz_eret;
    logic            issue;

    // Read view of the scoreboard with entry 0 tied to zero
    always_comb begin
        cnt_rd[0] = '0;
        for (int r = 1; r < 32; r++) begin
            cnt_rd[r] = cnt_q[r];
        end
    end

    // A source hazards when its producer needs more cycles than the
    // consumer can wait before using the operand
    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            logic [4:0]    src_addr;
            logic [TW-1:0] src_tuse;
            assign src_addr    = id_src_addr[5*i +: 5];
            assign src_tuse    = id_src_tuse[TW*i +: TW];
            assign data_hit[i] = id_valid & id_src_en[i] & (src_addr != 5'd0)
                               & (cnt_rd[src_addr] > src_tuse);
        end
    endgenerate

    // Hazard terms combine into the stall; a flush cancels the ID
    // instruction so it must never be held
    always_comb begin
        haz_data    = |data_hit;
        haz_md      = id_valid & id_md_use & (md_cnt_q != '0);
        haz_eret    = id_valid & id_eret & (epc_cnt_q != 2'd0);
        stall       = ~flush & (haz_data | haz_md | haz_eret);
        stall_cause = {3{~flush}} & {haz_eret, haz_md, haz_data};
        issue       = id_valid & ~stall & ~freeze & ~flush;
        md_busy     = (md_cnt_q != '0);
    end

    // Debug view: one bit per GPR with a result still in flight
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            pending_mask[r] = (cnt_rd[r] != '0);
        end
    end

    // Next GPR countdowns: flush clears, freeze holds, issue loads, else tick
    always_comb begin
        for (int r = 1; r < 32; r++) begin
            if (flush) begin
                cnt_d[r] = '0;
            end else if (freeze) begin
                cnt_d[r] = cnt_q[r];
            end else if (issue && id_dst_we && (id_dst_addr == 5'(r))) begin
                cnt_d[r] = id_tnew;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    // Next mult/div countdown: an in-flight operation survives a flush
    always_comb begin
        if (freeze) begin
            md_cnt_d = md_cnt_q;
        end else if (issue && id_md_start) begin
            md_cnt_d = id_md_is_div ? MD_DIV_LOAD : MD_MULT_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_ONE;
        end else begin
            md_cnt_d = md_cnt_q;
        end
    end

    // Next EPC-write countdown: only an MTC0 targeting EPC arms it
    always_comb begin
        if (flush) begin
            epc_cnt_d = 2'd0;
        end else if (freeze) begin
            epc_cnt_d = epc_cnt_q;
        end else if (issue && id_cp0_we && (id_cp0_addr == CP0_EPC)) begin
            epc_cnt_d = EPC_LOAD;
        end else if (epc_cnt_q != 2'd0) begin
            epc_cnt_d = epc_cnt_q - 2'd1;
        end else begin
            epc_cnt_d = epc_cnt_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
            md_cnt_q  <= '0;
            epc_cnt_q <= 2'd0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            md_cnt_q  <= md_cnt_d;
            epc_cnt_q <= epc_cnt_d;
        end
    end

endmodule
`default_nettype wire
